// File: rtl/ex_arith_units.sv
// Execute-stage arithmetic cluster: combinational ALU and branch unit,
// plus a two-cycle 32x32->64 multiplier with start/done handshake and flush.
module ex_arith_units (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  alu_op,
    input  logic [31:0] alu_a,
    input  logic [31:0] alu_b,
    output logic [31:0] alu_out,
    input  logic [2:0]  bru_op,
    input  logic [31:0] bru_a,
    input  logic [31:0] bru_b,
    output logic        bru_taken,
    input  logic        mul_en,
    input  logic        mul_signed,
    input  logic        mul_flush,
    input  logic [31:0] mul_a,
    input  logic [31:0] mul_b,
    output logic [63:0] mul_out,
    output logic        mul_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    logic [4:0]  w_sh;
    logic        w_alu_lt;
    logic        w_alu_ltu;
    logic [31:0] w_sra;

    assign w_sh      = alu_b[4:0];
    assign w_alu_lt  = $signed(alu_a) < $signed(alu_b);
    assign w_alu_ltu = alu_a < alu_b;
    assign w_sra     = $signed(alu_a) >>> w_sh;

    always_comb begin
        alu_out = 32'd0;
        case (alu_op)
            4'd0:    alu_out = alu_a + alu_b;
            4'd1:    alu_out = alu_a - alu_b;
            4'd2:    alu_out = {31'd0, w_alu_lt};
            4'd3:    alu_out = {31'd0, w_alu_ltu};
            4'd4:    alu_out = alu_a & alu_b;
            4'd5:    alu_out = alu_a | alu_b;
            4'd6:    alu_out = ~(alu_a | alu_b);
            4'd7:    alu_out = alu_a ^ alu_b;
            4'd8:    alu_out = alu_a << w_sh;
            4'd9:    alu_out = alu_a >> w_sh;
            4'd10:   alu_out = w_sra;
            4'd11:   alu_out = alu_b;
            default: alu_out = 32'd0;
        endcase
    end

    logic w_eq;
    logic w_lt;
    logic w_ltu;

    assign w_eq  = bru_a == bru_b;
    assign w_lt  = $signed(bru_a) < $signed(bru_b);
    assign w_ltu = bru_a < bru_b;

    always_comb begin
        bru_taken = 1'b0;
        case (bru_op)
            3'd0:    bru_taken = 1'b0;
            3'd1:    bru_taken = w_eq;
            3'd2:    bru_taken = ~w_eq;
            3'd3:    bru_taken = w_lt;
            3'd4:    bru_taken = ~w_lt;
            3'd5:    bru_taken = w_ltu;
            3'd6:    bru_taken = ~w_ltu;
            default: bru_taken = 1'b1;
        endcase
    end

    state_t      r_state;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic        r_signed;
    logic [63:0] r_out;
    logic        r_done;

    // Low 64 bits of the 33x33 product only need 64-bit extended operands.
    logic        w_sa;
    logic        w_sb;
    logic [63:0] w_xa;
    logic [63:0] w_xb;
    logic [63:0] w_prod;

    assign w_sa   = r_signed & r_a[31];
    assign w_sb   = r_signed & r_b[31];
    assign w_xa   = {{32{w_sa}}, r_a};
    assign w_xb   = {{32{w_sb}}, r_b};
    assign w_prod = w_xa * w_xb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_signed <= 1'b0;
            r_out    <= 64'd0;
            r_done   <= 1'b0;
        end else if (mul_flush) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (mul_en) begin
                        r_a      <= mul_a;
                        r_b      <= mul_b;
                        r_signed <= mul_signed;
                        r_state  <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_out   <= w_prod;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mul_out  = r_out;
    assign mul_done = r_done;

endmodule

// File: tb/tb_ex_arith_units.sv
// Self-checking bench for ex_arith_units: directed corner cases plus
// random ALU/BRU/multiplier traffic against a behavioural model.
module tb_ex_arith_units;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  alu_op;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [2:0]  bru_op;
    logic [31:0] bru_a, bru_b;
    logic        bru_taken;
    logic        mul_en, mul_signed, mul_flush;
    logic [31:0] mul_a, mul_b;
    logic [63:0] mul_out;
    logic        mul_done;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ex_arith_units dut (
        .clk(clk), .rst(rst),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
        .bru_op(bru_op), .bru_a(bru_a), .bru_b(bru_b), .bru_taken(bru_taken),
        .mul_en(mul_en), .mul_signed(mul_signed), .mul_flush(mul_flush),
        .mul_a(mul_a), .mul_b(mul_b), .mul_out(mul_out), .mul_done(mul_done)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] alu_model(input logic [3:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        int sa, sb;
        int unsigned sh;
        sa = int'(a);
        sb = int'(b);
        sh = int'(b) & 31;
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd3:  return (a < b) ? 32'd1 : 32'd0;
            4'd4:  return a & b;
            4'd5:  return a | b;
            4'd6:  return ~(a | b);
            4'd7:  return a ^ b;
            4'd8:  return 32'(longint'(a) * (longint'(1) << sh));
            4'd9:  return 32'(longint'(a) / (longint'(1) << sh));
            4'd10: return 32'(sa >>> sh);
            4'd11: return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic bru_model(input logic [2:0] op,
                                       input logic [31:0] a,
                                       input logic [31:0] b);
        longint sa, sb, ua, ub;
        sa = longint'(int'(a));
        sb = longint'(int'(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (op)
            3'd0: return 1'b0;
            3'd1: return ua == ub;
            3'd2: return ua != ub;
            3'd3: return sa < sb;
            3'd4: return sa >= sb;
            3'd5: return ua < ub;
            3'd6: return ua >= ub;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [63:0] mul_model(input logic [31:0] a,
                                              input logic [31:0] b,
                                              input logic s);
        longint pa, pb;
        if (s) begin
            pa = longint'(int'(a));
            pb = longint'(int'(b));
        end else begin
            pa = longint'({32'd0, a});
            pb = longint'({32'd0, b});
        end
        return 64'(pa * pb);
    endfunction

    task automatic alu_chk(input string tag, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp);
        alu_op = op; alu_a = a; alu_b = b;
        #1;
        check(tag, {32'd0, alu_out}, {32'd0, exp});
    endtask

    task automatic bru_chk(input string tag, input logic [2:0] op,
                           input logic exp);
        bru_op = op;
        #1;
        check(tag, {63'd0, bru_taken}, {63'd0, exp});
    endtask

    // Start at a posedge+1; check done timing and product.
    task automatic do_mul(input string tag, input logic [31:0] a,
                          input logic [31:0] b, input logic s,
                          input logic [63:0] exp);
        mul_a = a; mul_b = b; mul_signed = s; mul_en = 1'b1;
        @(posedge clk); #1;
        check({tag, "_e0done"}, {63'd0, mul_done}, 64'd0);
        @(posedge clk); #1;
        check({tag, "_done"}, {63'd0, mul_done}, 64'd1);
        check({tag, "_prod"}, mul_out, exp);
        mul_en = 1'b0;
        @(posedge clk); #1;
        check({tag, "_e2done"}, {63'd0, mul_done}, 64'd0);
        check({tag, "_hold"}, mul_out, exp);
    endtask

    initial begin
        logic [63:0] last;
        logic [31:0] ra, rb;
        logic        rs;
        rst = 1'b1;
        alu_op = '0; alu_a = '0; alu_b = '0;
        bru_op = '0; bru_a = '0; bru_b = '0;
        mul_en = 1'b0; mul_signed = 1'b0; mul_flush = 1'b0;
        mul_a = '0; mul_b = '0;
        #12;
        check("rst_out", mul_out, 64'd0);
        check("rst_done", {63'd0, mul_done}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        alu_chk("add", 4'd0, 32'h8000_0000, 32'd1, 32'h8000_0001);
        alu_chk("sub", 4'd1, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF);
        alu_chk("slt", 4'd2, 32'h8000_0000, 32'd1, 32'd1);
        alu_chk("sltu", 4'd3, 32'h8000_0000, 32'd1, 32'd0);
        alu_chk("nor", 4'd6, 32'h8000_0000, 32'd1, 32'h7FFF_FFFE);
        alu_chk("sra31", 4'd10, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF);
        alu_chk("srl31", 4'd9, 32'h8000_0000, 32'd31, 32'h0000_0001);
        alu_chk("passb", 4'd11, 32'h8000_0000, 32'd1, 32'd1);
        alu_chk("op13", 4'd13, 32'h8000_0000, 32'd1, 32'd0);

        bru_a = 32'hFFFF_FFFF; bru_b = 32'd0;
        bru_chk("eq", 3'd1, 1'b0);
        bru_chk("ne", 3'd2, 1'b1);
        bru_chk("lt", 3'd3, 1'b1);
        bru_chk("ge", 3'd4, 1'b0);
        bru_chk("ltu", 3'd5, 1'b0);
        bru_chk("geu", 3'd6, 1'b1);
        bru_chk("always", 3'd7, 1'b1);
        bru_chk("never", 3'd0, 1'b0);

        for (int i = 0; i < 300; i++) begin
            logic [3:0]  op;
            logic [31:0] a, b;
            op = 4'($urandom_range(0, 15));
            a = $urandom;
            b = (i % 4 == 0) ? a : $urandom;
            alu_chk("alu_rnd", op, a, b, alu_model(op, a, b));
        end
        for (int i = 0; i < 300; i++) begin
            logic [2:0] op;
            op = 3'($urandom_range(0, 7));
            bru_a = $urandom;
            bru_b = (i % 3 == 0) ? bru_a : $urandom;
            bru_chk("bru_rnd", op, bru_model(op, bru_a, bru_b));
        end

        do_mul("umul", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0,
               64'hFFFF_FFFE_0000_0001);
        do_mul("smul1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'd1);
        do_mul("smul2", 32'h8000_0000, 32'd2, 1'b1, 64'hFFFF_FFFF_0000_0000);
        last = 64'hFFFF_FFFF_0000_0000;

        // Flush while calculating.
        mul_a = 32'd11; mul_b = 32'd13; mul_signed = 1'b0; mul_en = 1'b1;
        @(posedge clk); #1;
        mul_flush = 1'b1; mul_en = 1'b0;
        @(posedge clk); #1;
        mul_flush = 1'b0;
        check("flush_done", {63'd0, mul_done}, 64'd0);
        check("flush_out", mul_out, last);
        @(posedge clk); #1;
        check("flush_done2", {63'd0, mul_done}, 64'd0);
        check("flush_out2", mul_out, last);
        do_mul("after_flush", 32'd3, 32'd5, 1'b0, 64'd15);

        // Operand change after capture.
        mul_a = 32'd7; mul_b = 32'd6; mul_signed = 1'b0; mul_en = 1'b1;
        @(posedge clk); #1;
        mul_a = 32'd9;
        @(posedge clk); #1;
        check("capture_done", {63'd0, mul_done}, 64'd1);
        check("capture_prod", mul_out, 64'd42);
        mul_en = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 25; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom);
            do_mul("mul_rnd", ra, rb, rs, mul_model(ra, rb, rs));
        end

        // Async reset mid-calculation.
        mul_a = 32'd100; mul_b = 32'd100; mul_signed = 1'b0; mul_en = 1'b1;
        @(posedge clk); #3;
        mul_en = 1'b0;
        rst = 1'b1;
        #1;
        check("arst_out", mul_out, 64'd0);
        check("arst_done", {63'd0, mul_done}, 64'd0);
        @(posedge clk); #1;
        check("arst_done2", {63'd0, mul_done}, 64'd0);
        rst = 1'b0;
        do_mul("after_rst", 32'd6, 32'd7, 1'b1, 64'd42);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
